// File: rtl/levit_frame_loader.sv
// Frame loader in front of the LeViT top: packs streamed rows into two ping-pong
// banks and presents each full bank as parallel row buses with a start enable.
module levit_frame_loader #(
   parameter int ROW_W  = 16,
   parameter int N_ROWS = 16,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [ROW_W-1:0]        s_data,
   input  logic                    s_last,
   input  logic                    core_end,
   output logic                    core_en,
   output logic [N_ROWS*ROW_W-1:0] o_rows,
   output logic                    frame_done,
   output logic [CNT_W-1:0]        frame_cnt,
   output logic                    err_last
);
   localparam int RW = $clog2(N_ROWS);
   localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);

   typedef enum logic [1:0] {IDLE, RUN, GAP} rd_state_t;

   logic [1:0][N_ROWS-1:0][ROW_W-1:0] bank_mem;
   logic [1:0]    bank_full;
   logic          wbank;
   logic          rbank;
   logic [RW-1:0] wcnt;
   logic          accept;
   logic          commit;
   logic          rel;
   rd_state_t     state;
   rd_state_t     state_nxt;

   assign s_ready = ~bank_full[wbank];
   assign accept  = s_valid & s_ready;
   assign commit  = accept & (wcnt == LAST_ROW);
   assign rel     = (state == RUN) & core_end;

   // The running bank is never the write bank, so o_rows stays frozen for the whole run.
   assign o_rows = bank_mem[rbank];

   // rstn deassertion is expected to arrive already synchronised to clk.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bank_mem <= '0;
         wcnt     <= '0;
         wbank    <= 1'b0;
         err_last <= 1'b0;
      end else if (accept) begin
         bank_mem[wbank][wcnt] <= s_data;
         if (commit) begin
            wcnt  <= '0;
            wbank <= ~wbank;
            if (!s_last) err_last <= 1'b1;
         end else if (s_last) begin
            // short frame: drop it, the bank stays empty and is refilled from row 0
            wcnt     <= '0;
            err_last <= 1'b1;
         end else begin
            wcnt <= wcnt + RW'(1);
         end
      end
   end

   // commit targets an empty bank and release a full one, so they never collide
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bank_full <= '0;
      end else begin
         if (commit) bank_full[wbank] <= 1'b1;
         if (rel)    bank_full[rbank] <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rbank     <= 1'b0;
         frame_cnt <= '0;
      end else if (rel) begin
         rbank     <= ~rbank;
         frame_cnt <= frame_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bank_full[rbank]) state_nxt = RUN;
         RUN:     if (core_end)         state_nxt = GAP;
         GAP:                           state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   // GAP forces at least one low cycle on core_en so every run starts on a fresh edge
   always_comb begin
      core_en    = 1'b0;
      frame_done = 1'b0;
      case (state)
         RUN:     core_en    = 1'b1;
         GAP:     frame_done = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_levit_frame_loader.sv
// Bench for levit_frame_loader: a queue/timestamp reference model checked every
// cycle, plus directed literal checks for latency, gaps, errors and stability.
module tb_levit_frame_loader;
   localparam int ROW_W  = 16;
   localparam int N_ROWS = 16;
   localparam int CNT_W  = 16;
   localparam int FW     = ROW_W * N_ROWS;

   logic             clk;
   logic             rstn;
   logic             s_valid;
   logic             s_ready;
   logic [ROW_W-1:0] s_data;
   logic             s_last;
   logic             core_end;
   logic             core_en;
   logic [FW-1:0]    o_rows;
   logic             frame_done;
   logic [CNT_W-1:0] frame_cnt;
   logic             err_last;

   levit_frame_loader #(.ROW_W(ROW_W), .N_ROWS(N_ROWS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .core_end(core_end), .core_en(core_en),
      .o_rows(o_rows), .frame_done(frame_done), .frame_cnt(frame_cnt),
      .err_last(err_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference model: frames as queue entries stamped with their commit edge
   int            e = 0;
   int            last_rel = -1000;
   int            wcnt_m = 0;
   logic [FW-1:0] part = '0;
   logic [FW-1:0] pend[$];
   int            pend_t[$];
   logic [FW-1:0] m_rows = '0;
   logic          m_en = 1'b0, m_done = 1'b0, m_err = 1'b0, m_ready = 1'b1;
   logic [CNT_W-1:0] m_cnt = '0;

   initial forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
         m_en = 0; m_done = 0; m_err = 0; m_ready = 1; m_cnt = '0; m_rows = '0;
         part = '0; wcnt_m = 0; pend.delete(); pend_t.delete(); last_rel = -1000;
      end else begin
         logic acc;
         e++;
         acc    = s_valid && m_ready;
         m_done = 0;
         if (m_en && core_end) begin
            m_en = 0; m_done = 1; m_cnt = m_cnt + 1'b1; last_rel = e;
         end else if (!m_en && pend.size() > 0 && pend_t[0] < e && last_rel <= e - 2) begin
            m_en = 1; m_rows = pend.pop_front(); void'(pend_t.pop_front());
         end
         if (acc) begin
            part[wcnt_m*ROW_W +: ROW_W] = s_data;
            if (wcnt_m == N_ROWS - 1) begin
               if (!s_last) m_err = 1;
               pend.push_back(part); pend_t.push_back(e); wcnt_m = 0;
            end else if (s_last) begin
               m_err = 1; wcnt_m = 0;
            end else begin
               wcnt_m++;
            end
         end
         m_ready = (pend.size() + (m_en ? 1 : 0)) < 2;
      end
   end

   initial forever begin
      @(negedge clk);
      chk("s_ready", s_ready, m_ready);
      chk("core_en", core_en, m_en);
      chk("frame_done", frame_done, m_done);
      chk("frame_cnt", frame_cnt, m_cnt);
      chk("err_last", err_last, m_err);
      if (m_en || !rstn) chk("o_rows", o_rows, m_rows);
   end

   // accelerator stand-in: ends each run after a fixed or random number of cycles
   int end_delay = 20;
   bit rnd_delay = 0;
   int spur_req = 0;
   int spur_ack = 0;
   initial begin
      int run_cyc = 0;
      int cur_delay = 20;
      core_end = 1'b0;
      forever begin
         @(negedge clk);
         if (core_en) begin
            run_cyc++;
            core_end = (run_cyc == cur_delay);
         end else begin
            run_cyc   = 0;
            core_end  = (spur_req != spur_ack);
            spur_ack  = spur_req;
            cur_delay = rnd_delay ? int'($urandom_range(1, 40)) : end_delay;
         end
      end
   end

   // monitor: done pulses, low gaps between runs, row stability during a run
   bit            track_gap = 0;
   int            done_cnt = 0, stab_bad = 0, low_len = 100;
   int            gmin = 999, gmax = 0, ngap = 0;
   logic          prev_en = 1'b0;
   logic [FW-1:0] cap = '0;
   initial forever begin
      @(negedge clk);
      if (!track_gap) begin gmin = 999; gmax = 0; ngap = 0; end
      if (frame_done) done_cnt++;
      if (core_en && !prev_en) begin
         if (track_gap && low_len < 10) begin
            ngap++;
            if (low_len < gmin) gmin = low_len;
            if (low_len > gmax) gmax = low_len;
         end
         cap = o_rows;
      end
      if (core_en && prev_en && o_rows !== cap) stab_bad++;
      low_len = core_en ? 0 : low_len + 1;
      prev_en = core_en;
   end

   // nb beats; s_last on beats whose index mod 16 equals la
   task automatic send(input int nb, input int la, input bit seq, input bit gaps, output int bp);
      int k = 0;
      int guard = 0;
      bp = 0;
      while (k < nb && guard < 3000) begin
         @(negedge clk);
         guard++;
         if (gaps && $urandom_range(0, 2) == 0) begin
            s_valid = 1'b0; s_last = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data  = seq ? ROW_W'(k + 1) : ROW_W'($urandom);
            s_last  = ((k % N_ROWS) == la);
         end
         #1;
         if (s_valid && s_ready) k++;
         else if (s_valid) bp++;
      end
      if (k < nb) chk("send_timeout", FW'(k), FW'(nb));
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!m_en && pend.size() == 0 && !core_en) begin ok = 1; break; end
      end
      if (!ok) chk("idle_timeout", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rstn = 1'b0;
      s_valid = 1'b0; s_last = 1'b0;
      @(negedge clk); #1;
      chk("rst_ready", s_ready, 1);
      chk("rst_en", core_en, 0);
      chk("rst_rows", o_rows, 0);
      chk("rst_err", err_last, 0);
      chk("rst_cnt", frame_cnt, 0);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int bp, d0, la, nb;
      logic [FW-1:0] exp;
      rstn = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      #1 rstn = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      // T1: reset mid-fill
      send(7, 15, 1, 0, bp);
      do_reset();

      // T2: single frame, latency and row mapping
      end_delay = 10;
      d0 = done_cnt;
      send(16, 15, 1, 0, bp);
      #1 chk("t2_en_early", core_en, 0);
      @(negedge clk); #1;
      chk("t2_en_rise", core_en, 1);
      for (int k = 0; k < N_ROWS; k++) exp[k*ROW_W +: ROW_W] = ROW_W'(k + 1);
      chk("t2_rows", o_rows, exp);
      chk("t2_row3", o_rows[63:48], 16'd4);
      wait_idle();
      chk("t2_cnt", frame_cnt, 1);
      chk("t2_done", FW'(done_cnt - d0), 1);

      // T3: ping-pong with backpressure
      end_delay = 30;
      track_gap = 1;
      send(48, 15, 0, 0, bp);
      chk("t3_backpressure", (bp > 0), 1);
      wait_idle();
      chk("t3_ngap", FW'(ngap), 2);
      chk("t3_gmin", FW'(gmin), 2);
      chk("t3_gmax", FW'(gmax), 2);
      chk("t3_cnt", frame_cnt, 4);
      track_gap = 0;

      // T4: short frame then a good one
      send(6, 5, 0, 0, bp);
      repeat (4) @(negedge clk);
      #1 chk("t4_err", err_last, 1);
      chk("t4_no_run", core_en, 0);
      send(16, 15, 0, 0, bp);
      wait_idle();
      chk("t4_cnt", frame_cnt, 5);

      // T5: missing s_last still runs
      do_reset();
      send(16, 99, 0, 0, bp);
      wait_idle();
      chk("t5_err", err_last, 1);
      chk("t5_cnt", frame_cnt, 1);

      // T6: valid toggling during a run, then a spurious core_end in IDLE
      end_delay = 25;
      send(16, 15, 0, 1, bp);
      send(16, 15, 0, 1, bp);
      wait_idle();
      chk("t6_stable", FW'(stab_bad), 0);
      d0 = done_cnt;
      spur_req++;
      repeat (4) @(negedge clk);
      #1 chk("t6_spur_en", core_en, 0);
      chk("t6_spur_cnt", frame_cnt, 3);
      chk("t6_spur_done", FW'(done_cnt - d0), 0);

      // random traffic against the model
      rnd_delay = 1;
      for (int f = 0; f < 24; f++) begin
         if ($urandom_range(0, 7) == 0) la = int'($urandom_range(0, 14));
         else if ($urandom_range(0, 7) == 0) la = 99;
         else la = 15;
         nb = (la < 15) ? la + 1 : 16;
         send(nb, la, 0, bit'($urandom_range(0, 1)), bp);
      end
      wait_idle();
      chk("final_stable", FW'(stab_bad), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
